// File: rtl/alu_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_sequencer_if
// Groups the two buses of alu_sequencer.
//   Instruction handshake: ins_valid/ins_ready, ins_opcode, ins_dst,
//                          ins_src_a, ins_src_b, ins_imm, ins_use_imm
//   ALU bus:               alu_opcode, alu_a, alu_b (to custom_alu)
//                          alu_result, alu_zero, alu_neg, alu_valid (from it)
// Modports:
//   slave  - the sequencer: accepts instructions, drives the ALU inputs
//   master - the environment: issues instructions and plays the ALU
// -----------------------------------------------------------------------------
interface alu_sequencer_if;
   logic        ins_valid;
   logic        ins_ready;
   logic [4:0]  ins_opcode;
   logic [2:0]  ins_dst;
   logic [2:0]  ins_src_a;
   logic [2:0]  ins_src_b;
   logic [15:0] ins_imm;
   logic        ins_use_imm;

   logic [4:0]  alu_opcode;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [15:0] alu_result;
   logic        alu_zero;
   logic        alu_neg;
   logic        alu_valid;

   modport slave (
      input  ins_valid, ins_opcode, ins_dst, ins_src_a, ins_src_b,
             ins_imm, ins_use_imm,
      output ins_ready,
      output alu_opcode, alu_a, alu_b,
      input  alu_result, alu_zero, alu_neg, alu_valid
   );

   modport master (
      output ins_valid, ins_opcode, ins_dst, ins_src_a, ins_src_b,
             ins_imm, ins_use_imm,
      input  ins_ready,
      input  alu_opcode, alu_a, alu_b,
      output alu_result, alu_zero, alu_neg, alu_valid
   );
endinterface

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Accepts one instruction at a time, reads operands from an 8-entry register
// file, runs them through an external custom_alu and writes back the result,
// updates flags, or records an action code.  One instruction per 4 cycles:
// IDLE -> ISSUE -> CAPT -> FLAGS -> IDLE; done pulses in FLAGS, 3 cycles after
// the transfer edge.  All updates of the FLAGS cycle land on its closing edge,
// so rd_data still shows the old register value while done is high.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   bus            alu_sequencer_if.slave: instruction handshake + ALU bus
//   err_clr        clears err_illegal and halted (a same-cycle set wins)
//   rd_addr/rd_data  combinational debug read of the register file
//   done, done_result  completion pulse and captured ALU result
//   flag_z, flag_n     flags of the last successfully completed instruction
//   action, action_strobe  last action code and its update pulse
//   err_illegal    sticky: ALU rejected an opcode (alu_valid low in CAPT)
//   halted         autostop state
//
// Build option: define ALU_SEQ_AUTOSTOP_EN to make an action result of
// ACTION_STOP halt instruction acceptance until err_clr.  Without it halted
// is tied low.
// -----------------------------------------------------------------------------
module alu_sequencer #(
   parameter int unsigned NREGS = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_sequencer_if.slave    bus,
   input  logic              err_clr,
   input  logic [2:0]        rd_addr,
   output logic [15:0]       rd_data,
   output logic              done,
   output logic [15:0]       done_result,
   output logic              flag_z,
   output logic              flag_n,
   output logic [15:0]       action,
   output logic              action_strobe,
   output logic              err_illegal,
   output logic              halted
);

   localparam logic [4:0] OP_NOP            = 5'h00;
   localparam logic [4:0] OP_MOV            = 5'h01;
   localparam logic [4:0] OP_LD             = 5'h02;
   localparam logic [4:0] OP_ST             = 5'h03;
   localparam logic [4:0] OP_ADD            = 5'h04;
   localparam logic [4:0] OP_SUB            = 5'h05;
   localparam logic [4:0] OP_AND            = 5'h06;
   localparam logic [4:0] OP_OR             = 5'h07;
   localparam logic [4:0] OP_NOT            = 5'h08;
   localparam logic [4:0] OP_JMP            = 5'h09;
   localparam logic [4:0] OP_OB_CHECK       = 5'h0A;
   localparam logic [4:0] OP_MOVE_LEFT      = 5'h0B;
   localparam logic [4:0] OP_MOVE_RIGHT     = 5'h0C;
   localparam logic [4:0] OP_STOP           = 5'h0D;
   localparam logic [4:0] OP_CONTINUE       = 5'h0E;
   localparam logic [4:0] OP_VELOCITY_GUARD = 5'h0F;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      CAPT  = 2'd2,
      FLAGS = 2'd3
   } state_t;

   state_t      state;
   state_t      state_d;

   logic [4:0]  op_q;
   logic [2:0]  dst_q;
   logic [15:0] a_q;
   logic [15:0] b_q;
   logic        valid_q;
   logic [15:0] regs [NREGS];

   logic        ready_c;
   logic [4:0]  alu_op_c;
   logic [15:0] alu_a_c;
   logic [15:0] alu_b_c;
   logic        xfer;
   logic        is_write;
   logic        is_action;
   logic        err_set;

   assign bus.ins_ready  = ready_c;
   assign bus.alu_opcode = alu_op_c;
   assign bus.alu_a      = alu_a_c;
   assign bus.alu_b      = alu_b_c;

   assign xfer    = bus.ins_valid & ready_c;
   assign err_set = (state == FLAGS) & ~valid_q;

   // reg[0] is never written, so it reads back 0 without a special case.
   assign rd_data = regs[rd_addr];

   // Writeback / action classification of the latched opcode.
   always_comb begin
      is_write  = 1'b0;
      is_action = 1'b0;
      case (op_q)
         OP_MOV, OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT:
            is_write = 1'b1;
         OP_OB_CHECK, OP_MOVE_LEFT, OP_MOVE_RIGHT, OP_STOP, OP_CONTINUE,
         OP_VELOCITY_GUARD:
            is_action = 1'b1;
         default: ;
      endcase
   end

   // Next state and per-state outputs.
   always_comb begin
      state_d       = state;
      ready_c       = 1'b0;
      alu_op_c      = OP_NOP;
      alu_a_c       = '0;
      alu_b_c       = '0;
      done          = 1'b0;
      action_strobe = 1'b0;
      case (state)
         IDLE: begin
            ready_c = ~halted;
            if (bus.ins_valid && !halted) state_d = ISSUE;
         end
         ISSUE: begin
            alu_op_c = op_q;
            alu_a_c  = a_q;
            alu_b_c  = b_q;
            state_d  = CAPT;
         end
         CAPT: begin
            state_d = FLAGS;
         end
         FLAGS: begin
            done          = 1'b1;
            action_strobe = valid_q & is_action;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         op_q        <= OP_NOP;
         dst_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         valid_q     <= 1'b0;
         done_result <= '0;
         flag_z      <= 1'b0;
         flag_n      <= 1'b0;
         action      <= '0;
         err_illegal <= 1'b0;
         regs        <= '{default: '0};
      end else begin
         state <= state_d;

         if (xfer) begin
            op_q  <= bus.ins_opcode;
            dst_q <= bus.ins_dst;
            a_q   <= regs[bus.ins_src_a];
            b_q   <= bus.ins_use_imm ? bus.ins_imm : regs[bus.ins_src_b];
         end

         if (state == CAPT) begin
            done_result <= bus.alu_result;
            valid_q     <= bus.alu_valid;
         end

         // The ALU's flags trail its result by one cycle, hence FLAGS samples them.
         if (state == FLAGS && valid_q) begin
            flag_z <= bus.alu_zero;
            flag_n <= bus.alu_neg;
            if (is_write && dst_q != 3'd0) regs[dst_q] <= done_result;
            if (is_action) action <= done_result;
         end

         if (err_set)      err_illegal <= 1'b1;
         else if (err_clr) err_illegal <= 1'b0;
      end
   end

`ifdef ALU_SEQ_AUTOSTOP_EN
   localparam logic [15:0] ACTION_STOP = 16'h0003;

   logic halt_set;
   logic halted_q;

   assign halt_set = (state == FLAGS) & valid_q & is_action &
                     (done_result == ACTION_STOP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        halted_q <= 1'b0;
      else if (halt_set) halted_q <= 1'b1;
      else if (err_clr)  halted_q <= 1'b0;
   end

   assign halted = halted_q;
`else
   assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
// Directed bench for alu_sequencer.  A small registered model stands in for
// custom_alu (result one cycle after ISSUE, flags one cycle after the result).
// Expected values are hand-computed constants in the vector table.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_sequencer;

   localparam logic [4:0] OP_NOP            = 5'h00;
   localparam logic [4:0] OP_MOV            = 5'h01;
   localparam logic [4:0] OP_LD             = 5'h02;
   localparam logic [4:0] OP_ST             = 5'h03;
   localparam logic [4:0] OP_ADD            = 5'h04;
   localparam logic [4:0] OP_SUB            = 5'h05;
   localparam logic [4:0] OP_AND            = 5'h06;
   localparam logic [4:0] OP_OR             = 5'h07;
   localparam logic [4:0] OP_NOT            = 5'h08;
   localparam logic [4:0] OP_JMP            = 5'h09;
   localparam logic [4:0] OP_OB_CHECK       = 5'h0A;
   localparam logic [4:0] OP_MOVE_LEFT      = 5'h0B;
   localparam logic [4:0] OP_MOVE_RIGHT     = 5'h0C;
   localparam logic [4:0] OP_STOP           = 5'h0D;
   localparam logic [4:0] OP_CONTINUE       = 5'h0E;
   localparam logic [4:0] OP_VELOCITY_GUARD = 5'h0F;
   localparam logic [4:0] OP_ILLEGAL        = 5'h1F;

   localparam logic [15:0] ACTION_LEFT = 16'h0001;
   localparam logic [15:0] ACTION_STOP = 16'h0003;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        err_clr;
   logic [2:0]  rd_addr;
   logic [15:0] rd_data;
   logic        done;
   logic [15:0] done_result;
   logic        flag_z;
   logic        flag_n;
   logic [15:0] action;
   logic        action_strobe;
   logic        err_illegal;
   logic        halted;

   int n_checks = 0;
   int n_pass   = 0;

   alu_sequencer_if bus ();

   alu_sequencer #(.NREGS(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus),
      .err_clr       (err_clr),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .done          (done),
      .done_result   (done_result),
      .flag_z        (flag_z),
      .flag_n        (flag_n),
      .action        (action),
      .action_strobe (action_strobe),
      .err_illegal   (err_illegal),
      .halted        (halted)
   );

   always #5 clk = ~clk;

   // custom_alu stand-in: {valid, result}
   function automatic logic [16:0] alu_model(input logic [4:0] op,
                                             input logic [15:0] a, b);
      case (op)
         OP_NOP:                  return {1'b1, 16'h0000};
         OP_MOV, OP_LD, OP_JMP:   return {1'b1, b};
         OP_ST:                   return {1'b1, a};
         OP_ADD:                  return {1'b1, 16'(a + b)};
         OP_SUB:                  return {1'b1, 16'(a - b)};
         OP_AND:                  return {1'b1, a & b};
         OP_OR:                   return {1'b1, a | b};
         OP_NOT:                  return {1'b1, ~a};
         OP_MOVE_LEFT:            return {1'b1, ACTION_LEFT};
         OP_MOVE_RIGHT:           return {1'b1, 16'h0002};
         OP_STOP:                 return {1'b1, ACTION_STOP};
         OP_CONTINUE:             return {1'b1, 16'h0004};
         OP_OB_CHECK:             return {1'b1, 16'h0005};
         OP_VELOCITY_GUARD:       return {1'b1, 16'h0006};
         default:                 return {1'b0, 16'hDEAD};
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.alu_result <= '0;
         bus.alu_valid  <= 1'b1;
         bus.alu_zero   <= 1'b0;
         bus.alu_neg    <= 1'b0;
      end else begin
         {bus.alu_valid, bus.alu_result} <= alu_model(bus.alu_opcode, bus.alu_a, bus.alu_b);
         bus.alu_zero <= (bus.alu_result == 16'h0000);
         bus.alu_neg  <= bus.alu_result[15];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic read_reg(input logic [2:0] a, output logic [15:0] d);
      rd_addr = a;
      #1;
      d = rd_data;
   endtask

   // Issues one instruction and waits for done.  Returns the number of falling
   // edges from the transfer edge to done (0 if never seen), the ALU opcode
   // seen in the first cycle after transfer, action_strobe and rd_data while
   // done is high.  Returns at posedge+1 after the done cycle.
   task automatic run_instr(input logic [4:0] op, input logic [2:0] dst, sa, sb,
                            input logic [15:0] imm, input logic use_imm,
                            output int lat, output logic [4:0] iss_op,
                            output logic strobe, output logic [15:0] rd_at_done);
      int  n;
      bit  seen;
      lat = 0; iss_op = '0; strobe = 1'b0; rd_at_done = '0; seen = 0; n = 0;
      @(negedge clk);
      while (!bus.ins_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.ins_ready) begin
         check("ready_wait", 32'(bus.ins_ready), 32'd1);
         return;
      end
      bus.ins_opcode  = op;
      bus.ins_dst     = dst;
      bus.ins_src_a   = sa;
      bus.ins_src_b   = sb;
      bus.ins_imm     = imm;
      bus.ins_use_imm = use_imm;
      bus.ins_valid   = 1'b1;
      @(posedge clk);
      #1 bus.ins_valid = 1'b0;
      for (int k = 1; k <= 8 && !seen; k++) begin
         @(negedge clk);
         if (k == 1) iss_op = bus.alu_opcode;
         if (done) begin
            seen       = 1;
            lat        = k;
            strobe     = action_strobe;
            rd_at_done = rd_data;
         end
      end
      if (seen) begin
         @(posedge clk);
         #1;
      end
   endtask

   typedef struct {
      logic [4:0]  op;
      logic [2:0]  dst, sa, sb;
      logic [15:0] imm;
      logic        use_imm;
      logic [15:0] exp_res;
      logic        exp_z, exp_n;
      logic [2:0]  chk_reg;
      logic [15:0] exp_reg;
   } vec_t;

   vec_t vecs [14];

   initial begin
      int          lat;
      logic [4:0]  iss_op;
      logic        strobe;
      logic [15:0] rdd;
      logic [15:0] d;
      bit          done_seen;

      vecs[0]  = '{OP_MOV, 3'd1, 3'd0, 3'd0, 16'h1234, 1'b1, 16'h1234, 1'b0, 1'b0, 3'd1, 16'h1234};
      vecs[1]  = '{OP_MOV, 3'd1, 3'd0, 3'd0, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0, 1'b1, 3'd1, 16'hFFFF};
      vecs[2]  = '{OP_ADD, 3'd2, 3'd1, 3'd0, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b0, 3'd2, 16'h0000};
      vecs[3]  = '{OP_SUB, 3'd3, 3'd0, 3'd0, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b1, 3'd3, 16'hFFFF};
      vecs[4]  = '{OP_MOV, 3'd5, 3'd0, 3'd0, 16'h0F0F, 1'b1, 16'h0F0F, 1'b0, 1'b0, 3'd5, 16'h0F0F};
      vecs[5]  = '{OP_AND, 3'd4, 3'd1, 3'd5, 16'h0000, 1'b0, 16'h0F0F, 1'b0, 1'b0, 3'd4, 16'h0F0F};
      vecs[6]  = '{OP_OR,  3'd6, 3'd5, 3'd0, 16'hF000, 1'b1, 16'hFF0F, 1'b0, 1'b1, 3'd6, 16'hFF0F};
      vecs[7]  = '{OP_NOT, 3'd7, 3'd5, 3'd0, 16'h0000, 1'b1, 16'hF0F0, 1'b0, 1'b1, 3'd7, 16'hF0F0};
      vecs[8]  = '{OP_ST,  3'd2, 3'd1, 3'd0, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b1, 3'd2, 16'h0000};
      vecs[9]  = '{OP_MOV, 3'd0, 3'd0, 3'd0, 16'h0055, 1'b1, 16'h0055, 1'b0, 1'b0, 3'd0, 16'h0000};
      vecs[10] = '{OP_ADD, 3'd7, 3'd7, 3'd0, 16'h0F10, 1'b1, 16'h0000, 1'b1, 1'b0, 3'd7, 16'h0000};
      vecs[11] = '{OP_LD,  3'd2, 3'd0, 3'd0, 16'h8001, 1'b1, 16'h8001, 1'b0, 1'b1, 3'd2, 16'h8001};
      vecs[12] = '{OP_JMP, 3'd3, 3'd0, 3'd0, 16'h0042, 1'b1, 16'h0042, 1'b0, 1'b0, 3'd3, 16'hFFFF};
      vecs[13] = '{OP_SUB, 3'd6, 3'd4, 3'd5, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 3'd6, 16'h0000};

      rst_n = 1'b0; err_clr = 1'b0; rd_addr = '0;
      bus.ins_valid = 1'b0; bus.ins_opcode = '0; bus.ins_dst = '0;
      bus.ins_src_a = '0; bus.ins_src_b = '0; bus.ins_imm = '0; bus.ins_use_imm = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_done",     32'(done), 32'd0);
      check("rst_alu_op",   32'(bus.alu_opcode), 32'(OP_NOP));
      check("rst_err",      32'(err_illegal), 32'd0);
      check("rst_halted",   32'(halted), 32'd0);
      check("rst_action",   32'(action), 32'd0);
      check("rst_flags",    32'({flag_z, flag_n}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready",    32'(bus.ins_ready), 32'd1);
      read_reg(3'd1, d);
      check("rst_reg1",     32'(d), 32'd0);

      // Table-driven instructions
      for (int i = 0; i < 14; i++) begin
         run_instr(vecs[i].op, vecs[i].dst, vecs[i].sa, vecs[i].sb, vecs[i].imm,
                   vecs[i].use_imm, lat, iss_op, strobe, rdd);
         check($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
         check($sformatf("v%0d_issue_op", i), 32'(iss_op), 32'(vecs[i].op));
         check($sformatf("v%0d_result", i), 32'(done_result), 32'(vecs[i].exp_res));
         check($sformatf("v%0d_flag_z", i), 32'(flag_z), 32'(vecs[i].exp_z));
         check($sformatf("v%0d_flag_n", i), 32'(flag_n), 32'(vecs[i].exp_n));
         check($sformatf("v%0d_strobe", i), 32'(strobe), 32'd0);
         read_reg(vecs[i].chk_reg, d);
         check($sformatf("v%0d_reg", i), 32'(d), 32'(vecs[i].exp_reg));
      end
      check("alu_op_idle", 32'(bus.alu_opcode), 32'(OP_NOP));

      // rd_data shows the old value during the writeback cycle
      rd_addr = 3'd1;
      run_instr(OP_MOV, 3'd1, 3'd0, 3'd0, 16'hABCD, 1'b1, lat, iss_op, strobe, rdd);
      check("prewrite_rd", 32'(rdd), 32'hFFFF);
      read_reg(3'd1, d);
      check("postwrite_rd", 32'(d), 32'hABCD);

      // Illegal opcode: flags now z=0 n=1 from 0xABCD? no: 0xABCD has bit15 set
      run_instr(OP_ILLEGAL, 3'd1, 3'd0, 3'd0, 16'h1111, 1'b1, lat, iss_op, strobe, rdd);
      check("ill_latency", 32'(lat), 32'd3);
      check("ill_err",     32'(err_illegal), 32'd1);
      check("ill_flags",   32'({flag_z, flag_n}), 32'b01);
      check("ill_strobe",  32'(strobe), 32'd0);
      read_reg(3'd1, d);
      check("ill_reg1",    32'(d), 32'hABCD);

      // err_clr held across a second illegal op: the set in FLAGS wins
      err_clr = 1'b1;
      run_instr(OP_ILLEGAL, 3'd2, 3'd0, 3'd0, 16'h2222, 1'b1, lat, iss_op, strobe, rdd);
      check("ill2_err_set_wins", 32'(err_illegal), 32'd1);
      err_clr = 1'b0;
      read_reg(3'd2, d);
      check("ill2_reg2",   32'(d), 32'h8001);
      @(negedge clk) err_clr = 1'b1;
      @(negedge clk) err_clr = 1'b0;
      check("err_cleared", 32'(err_illegal), 32'd0);

      // Action opcode
      run_instr(OP_MOVE_LEFT, 3'd5, 3'd0, 3'd0, 16'h0000, 1'b1, lat, iss_op, strobe, rdd);
      check("left_latency", 32'(lat), 32'd3);
      check("left_strobe",  32'(strobe), 32'd1);
      check("left_action",  32'(action), 32'(ACTION_LEFT));
      read_reg(3'd5, d);
      check("left_reg5",    32'(d), 32'h0F0F);

      // Stop action
      run_instr(OP_STOP, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b1, lat, iss_op, strobe, rdd);
      check("stop_action",  32'(action), 32'(ACTION_STOP));
`ifdef ALU_SEQ_AUTOSTOP_EN
      check("stop_halted",  32'(halted), 32'd1);
      check("stop_ready0",  32'(bus.ins_ready), 32'd0);
      repeat (3) @(negedge clk);
      check("stop_ready_hold", 32'(bus.ins_ready), 32'd0);
      err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
      check("stop_unhalted", 32'(halted), 32'd0);
      check("stop_ready1",   32'(bus.ins_ready), 32'd1);
`else
      check("stop_halted",  32'(halted), 32'd0);
      check("stop_ready1",  32'(bus.ins_ready), 32'd1);
`endif

      // Reset asserted during CAPT of MOV dst=4
      @(negedge clk);
      bus.ins_opcode = OP_MOV; bus.ins_dst = 3'd4; bus.ins_imm = 16'h7777;
      bus.ins_use_imm = 1'b1; bus.ins_valid = 1'b1;
      @(posedge clk);
      #1 bus.ins_valid = 1'b0;
      @(negedge clk);            // ISSUE
      @(negedge clk);            // CAPT
      rst_n = 1'b0;
      #1;
      check("rstmid_done",  32'(done), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      done_seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (done) done_seen = 1;
      end
      check("rstmid_no_done", 32'(done_seen), 32'd0);
      check("rstmid_ready",   32'(bus.ins_ready), 32'd1);
      read_reg(3'd4, d);
      check("rstmid_reg4",    32'(d), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
